// File: rtl/immediate_generator_pkg.sv
// -----------------------------------------------------------------------------
// immediate_generator_pkg
// Shared definitions for the pipelined immediate generator:
//   - imm_src_e    : immediate format select codes (6 and 7 are unused/illegal)
//   - imm_result_t : 32-bit extended immediate plus illegal-format flag
//   - imm_extract  : combinational decode of one RV32I immediate / CSR zimm
//   - IMM_W        : native immediate width before widening to XLEN
// -----------------------------------------------------------------------------
package immediate_generator_pkg;

  localparam int unsigned IMM_W = 32;

  typedef enum logic [2:0] {
    I_TYPE = 3'd0,
    S_TYPE = 3'd1,
    B_TYPE = 3'd2,
    U_TYPE = 3'd3,
    J_TYPE = 3'd4,
    Z_TYPE = 3'd5
  } imm_src_e;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic             illegal;
  } imm_result_t;

  // Returns the immediate already extended to 32 bits. Every signed format
  // takes its sign from instr[31]; the zimm is zero-extended, so bit 31 of the
  // result is always 0 for Z_TYPE and widening to XLEN can use bit 31 uniformly.
  function automatic imm_result_t imm_extract(input logic [31:0] instr,
                                              input logic [2:0]  src);
    imm_result_t res;
    res.imm     = '0;
    res.illegal = 1'b0;
    case (src)
      I_TYPE: res.imm = {{20{instr[31]}}, instr[31:20]};
      S_TYPE: res.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      B_TYPE: res.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
      U_TYPE: res.imm = {instr[31:12], 12'b0};
      J_TYPE: res.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
      Z_TYPE: res.imm = {27'b0, instr[19:15]};
      default: begin
        // Unused encodings: zero immediate, flagged so execute can trap.
        res.imm     = '0;
        res.illegal = 1'b1;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// -----------------------------------------------------------------------------
// imm_skid_buf
// Two-entry valid/ready buffer: a main output register plus one skid register.
// in_ready is registered (true while the skid entry is empty) so there is no
// combinational path from out_ready back to in_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, discards all entries
//   in_valid   in   upstream data valid
//   in_ready   out  buffer can accept this cycle (registered)
//   in_data    in   payload, W bits
//   out_valid  out  main register holds a transaction
//   out_ready  in   downstream accepts the main register
//   out_data   out  main register contents, stable while stalled
// -----------------------------------------------------------------------------
module imm_skid_buf #(
  parameter int unsigned W = 41
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Occupancy: EMPTY = nothing held, ONE = main register only,
  // FULL = main and skid registers both hold data.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   w_state_next;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_in_ready;
  logic         w_accept;
  logic         w_drain;

  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;
  assign in_ready  = r_in_ready;

  assign w_accept  = in_valid && r_in_ready;
  assign w_drain   = out_valid && out_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_state_next = ST_ONE;
      end
      ST_ONE: begin
        if (w_accept && !w_drain)      w_state_next = ST_FULL;
        else if (w_drain && !w_accept) w_state_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_drain) w_state_next = ST_ONE;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      // Look-ahead on the next state keeps in_ready a pure flop output.
      r_in_ready <= (w_state_next != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (r_state == ST_FULL) begin
      // in_ready is low here, so only the skid-to-main move can happen.
      if (w_drain) r_main <= r_skid;
    end else if (w_accept) begin
      // Output free (empty, or being drained this cycle): bypass the skid.
      if (r_state == ST_EMPTY || w_drain) r_main <= in_data;
      else                                r_skid <= in_data;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator between decode and the execute operand mux.
// Decodes I/S/B/U/J immediates and the CSR zimm, widens them to XLEN, and
// registers them together with an opaque sideband tag behind a valid/ready
// handshake with a two-entry skid buffer (latency 1, throughput 1/cycle).
//
// Parameters:
//   XLEN   output immediate width (32 or 64)
//   TAG_W  sideband tag width (1..64)
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   in_valid/ready  input handshake (in_ready is registered)
//   in_instruction  raw 32-bit instruction word
//   ImmSrc          format select, see imm_src_e; codes 6/7 are illegal
//   in_tag          sideband tag travelling with the instruction
//   out_valid/ready output handshake
//   out_immediate   XLEN-bit extended immediate (0 for illegal codes)
//   out_tag         tag belonging to out_immediate
//   out_illegal     ImmSrc was an unused encoding
//   illegal_cnt     16-bit saturating count of accepted illegal selects;
//                   present only when IMM_GEN_ILLEGAL_CNT_EN is defined
// -----------------------------------------------------------------------------
module imm_gen_pipe
  import immediate_generator_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instruction,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_immediate,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
`ifdef IMM_GEN_ILLEGAL_CNT_EN
  ,
  output logic [15:0]      illegal_cnt
`endif
);

  // Payload layout: {illegal, tag, immediate}
  localparam int unsigned PAY_W = XLEN + TAG_W + 1;

  imm_result_t      w_ext;
  logic [XLEN-1:0]  w_imm_xlen;
  logic [PAY_W-1:0] w_in_payload;
  logic [PAY_W-1:0] w_out_payload;

  assign w_ext = imm_extract(in_instruction, ImmSrc);

  // Widening from bit 31 is correct for every format: U-type is defined to
  // sign-extend from bit 31 at XLEN=64, and the zimm already has bit 31 clear.
  generate
    if (XLEN > IMM_W) begin : g_wide
      assign w_imm_xlen = {{(XLEN-IMM_W){w_ext.imm[IMM_W-1]}}, w_ext.imm};
    end else begin : g_narrow
      assign w_imm_xlen = w_ext.imm[XLEN-1:0];
    end
  endgenerate

  assign w_in_payload = {w_ext.illegal, in_tag, w_imm_xlen};

  imm_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_payload)
  );

  assign out_immediate = w_out_payload[XLEN-1:0];
  assign out_tag       = w_out_payload[XLEN +: TAG_W];
  assign out_illegal   = w_out_payload[PAY_W-1];

`ifdef IMM_GEN_ILLEGAL_CNT_EN
  logic [15:0] r_illegal_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (in_valid && in_ready && w_ext.illegal &&
                 (r_illegal_cnt != 16'hFFFF)) begin
      r_illegal_cnt <= r_illegal_cnt + 16'd1;
    end
  end

  assign illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Two instances (XLEN=32 and XLEN=64) driven from one directed sequence.
// Expected results are pushed when a transfer is accepted and popped when the
// DUT hands an output over; IMM_GEN_ILLEGAL_CNT_EN enables the counter checks.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;
  import immediate_generator_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, or32, ill32;
  logic [31:0] ins32;
  logic [2:0]  src32;
  logic [7:0]  itag32, otag32;
  logic [31:0] oimm32;

  logic        iv64, ir64, ov64, or64, ill64;
  logic [31:0] ins64;
  logic [2:0]  src64;
  logic [7:0]  itag64, otag64;
  logic [63:0] oimm64;

`ifdef IMM_GEN_ILLEGAL_CNT_EN
  logic [15:0] cnt32, cnt64;
`endif

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (iv32),
    .in_ready       (ir32),
    .in_instruction (ins32),
    .ImmSrc         (src32),
    .in_tag         (itag32),
    .out_valid      (ov32),
    .out_ready      (or32),
    .out_immediate  (oimm32),
    .out_tag        (otag32),
    .out_illegal    (ill32)
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    ,
    .illegal_cnt    (cnt32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (iv64),
    .in_ready       (ir64),
    .in_instruction (ins64),
    .ImmSrc         (src64),
    .in_tag         (itag64),
    .out_valid      (ov64),
    .out_ready      (or64),
    .out_immediate  (oimm64),
    .out_tag        (otag64),
    .out_illegal    (ill64)
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    ,
    .illegal_cnt    (cnt64)
`endif
  );

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t pend32, pend64;
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic acc32     = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive32(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [7:0] tag, input logic [63:0] eimm, input logic eill);
    iv32 = v; ins32 = ins; src32 = src; itag32 = tag;
    pend32.imm = eimm; pend32.tag = tag; pend32.ill = eill;
  endtask

  task automatic drive64(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [7:0] tag, input logic [63:0] eimm, input logic eill);
    iv64 = v; ins64 = ins; src64 = src; itag64 = tag;
    pend64.imm = eimm; pend64.tag = tag; pend64.ill = eill;
  endtask

  // Sample both interfaces on the falling edge, update the scoreboards, then
  // return 1 time unit after the next rising edge, ready for new stimulus.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc32 = iv32 && ir32;
    if (acc32) q32.push_back(pend32);
    if (iv64 && ir64) q64.push_back(pend64);
    if (ov32 && or32) begin
      n_asserts++;
      assert (q32.size() > 0) else begin
        n_fail++;
        $error("FAIL sb32_unexpected_output: observed tag 0x%0h expected no output", otag32);
      end
      if (q32.size() > 0) begin
        e = q32.pop_front();
        $display("txn dut32 tag=0x%02h imm=0x%08h illegal=%0b", otag32, oimm32, ill32);
        check("sb32_imm", 64'(oimm32), e.imm);
        check("sb32_tag", 64'(otag32), 64'(e.tag));
        check("sb32_illegal", 64'(ill32), 64'(e.ill));
      end
    end
    if (ov64 && or64) begin
      n_asserts++;
      assert (q64.size() > 0) else begin
        n_fail++;
        $error("FAIL sb64_unexpected_output: observed tag 0x%0h expected no output", otag64);
      end
      if (q64.size() > 0) begin
        e = q64.pop_front();
        $display("txn dut64 tag=0x%02h imm=0x%016h illegal=%0b", otag64, oimm64, ill64);
        check("sb64_imm", oimm64, e.imm);
        check("sb64_tag", 64'(otag64), 64'(e.tag));
        check("sb64_illegal", 64'(ill64), 64'(e.ill));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    drive32(1'b0, 32'h0, 3'd0, 8'h0, 64'h0, 1'b0);
    drive64(1'b0, 32'h0, 3'd0, 8'h0, 64'h0, 1'b0);
    or32 = 1'b1;
    or64 = 1'b1;

    // Reset asserted before any clock edge: outputs must clear on their own.
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid32", 64'(ov32), 64'd0);
    check("rst_out_imm32", 64'(oimm32), 64'd0);
    check("rst_out_tag32", 64'(otag32), 64'd0);
    check("rst_out_illegal32", 64'(ill32), 64'd0);
    check("rst_out_valid64", 64'(ov64), 64'd0);
    check("rst_out_imm64", oimm64, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready32", 64'(ir32), 64'd1);
    check("rst_in_ready64", 64'(ir64), 64'd1);
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    check("rst_illegal_cnt", 64'(cnt32), 64'd0);
`endif

    // XLEN=32 back-to-back, out_ready held high.
    drive32(1'b1, 32'hFFF00093, I_TYPE, 8'h01, 64'hFFFFFFFF, 1'b0);
    check("b2b_in_ready_1", 64'(ir32), 64'd1);
    tick();
    drive32(1'b1, 32'hFE112E23, S_TYPE, 8'h02, 64'hFFFFFFFC, 1'b0);
    check("b2b_latency1_valid", 64'(ov32), 64'd1);
    check("b2b_in_ready_2", 64'(ir32), 64'd1);
    tick();
    drive32(1'b1, 32'hFF9FF06F, J_TYPE, 8'h03, 64'hFFFFFFF8, 1'b0);
    check("b2b_valid_2", 64'(ov32), 64'd1);
    check("b2b_in_ready_3", 64'(ir32), 64'd1);
    tick();
    drive32(1'b1, 32'hFE000EE3, B_TYPE, 8'h04, 64'hFFFFFFFC, 1'b0);
    check("b2b_valid_3", 64'(ov32), 64'd1);
    check("b2b_in_ready_4", 64'(ir32), 64'd1);
    tick();
    drive32(1'b0, 32'h0, 3'd0, 8'h0, 64'h0, 1'b0);
    check("b2b_valid_4", 64'(ov32), 64'd1);
    tick();
    check("b2b_drained_valid", 64'(ov32), 64'd0);
    check("b2b_queue_empty", 64'(q32.size()), 64'd0);

    // XLEN=64: U sign extension from bit 31, zimm, I sign extension.
    drive64(1'b1, 32'h123450B7, U_TYPE, 8'h10, 64'h0000000012345000, 1'b0);
    tick();
    drive64(1'b1, 32'h800000B7, U_TYPE, 8'h11, 64'hFFFFFFFF80000000, 1'b0);
    tick();
    drive64(1'b1, 32'h0002D073, Z_TYPE, 8'h12, 64'h0000000000000005, 1'b0);
    tick();
    drive64(1'b1, 32'hFFF00093, I_TYPE, 8'h13, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    tick();
    drive64(1'b0, 32'h0, 3'd0, 8'h0, 64'h0, 1'b0);
    tick();
    tick();
    check("x64_queue_empty", 64'(q64.size()), 64'd0);

    // Illegal selects: zero immediate, flag set, tag passed through.
    drive32(1'b1, 32'hFFFFFFFF, 3'd7, 8'h5A, 64'h0, 1'b1);
    tick();
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    check("illegal_cnt_first", 64'(cnt32), 64'd1);
`endif
    drive32(1'b1, 32'hFFFFF0FF, 3'd6, 8'h5B, 64'h0, 1'b1);
    check("illegal_out_valid", 64'(ov32), 64'd1);
    check("illegal_out_tag", 64'(otag32), 64'h5A);
    tick();
    drive32(1'b0, 32'h0, 3'd0, 8'h0, 64'h0, 1'b0);
    tick();
    tick();
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    check("illegal_cnt_second", 64'(cnt32), 64'd2);
`endif
    check("illegal_queue_empty", 64'(q32.size()), 64'd0);

    // Backpressure: stream tags 1..6, consumer stalled for the first 3 cycles.
    k = 1;
    for (int c = 0; c < 24 && k <= 6; c++) begin
      or32 = (c >= 3);
      drive32(1'b1, {12'h800 + 12'(k), 20'h00093}, I_TYPE, 8'(k),
              64'(32'hFFFFF800 + 32'(k)), 1'b0);
      if (c == 1) begin
        check("bp_hold_valid_c1", 64'(ov32), 64'd1);
        check("bp_hold_tag_c1", 64'(otag32), 64'd1);
      end
      if (c == 2) begin
        check("bp_in_ready_low", 64'(ir32), 64'd0);
        check("bp_hold_tag_c2", 64'(otag32), 64'd1);
        check("bp_hold_imm_c2", 64'(oimm32), 64'hFFFFF801);
      end
      tick();
      if (acc32) k++;
    end
    check("bp_accept_count", 64'(k), 64'd7);
    drive32(1'b0, 32'h0, 3'd0, 8'h0, 64'h0, 1'b0);
    tick();
    tick();
    tick();
    check("bp_queue_empty", 64'(q32.size()), 64'd0);
    check("bp_drained_valid", 64'(ov32), 64'd0);

    // Reset while both entries are occupied.
    or32 = 1'b0;
    drive32(1'b1, 32'h00100093, I_TYPE, 8'hA1, 64'h1, 1'b0);
    tick();
    drive32(1'b1, 32'h00200093, I_TYPE, 8'hA2, 64'h2, 1'b0);
    tick();
    drive32(1'b0, 32'h0, 3'd0, 8'h0, 64'h0, 1'b0);
    check("full_in_ready_low", 64'(ir32), 64'd0);
    check("full_out_valid", 64'(ov32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ov32), 64'd0);
    check("midrst_out_tag", 64'(otag32), 64'd0);
    check("midrst_out_imm", 64'(oimm32), 64'd0);
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    check("midrst_illegal_cnt", 64'(cnt32), 64'd0);
`endif
    q32.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    check("postrst_in_ready", 64'(ir32), 64'd1);
    check("postrst_out_valid", 64'(ov32), 64'd0);
    or32 = 1'b1;
    tick();
    tick();
    tick();
    check("postrst_no_stale", 64'(ov32), 64'd0);
    drive32(1'b1, 32'h7FF00093, I_TYPE, 8'hC3, 64'h7FF, 1'b0);
    tick();
    drive32(1'b0, 32'h0, 3'd0, 8'h0, 64'h0, 1'b0);
    tick();
    tick();

    check("final_queue32_empty", 64'(q32.size()), 64'd0);
    check("final_queue64_empty", 64'(q64.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator.
- Decodes and sign-extends every RV32I immediate format, plus the CSR zimm, to XLEN bits.
- Registered output behind a valid/ready handshake with a 2-entry skid buffer. Sits between the decode stage and the execute-stage operand mux.
- Carries an opaque sideband tag (PC or ROB index) alongside each immediate.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 8, sideband tag width carried with each transaction; 1..64.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction and ImmSrc valid
- in_ready  out  1  block can accept input this cycle
- in_instruction  in  32  raw instruction word
- ImmSrc  in  3  immediate format select (imm_src_e)
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output transaction valid
- out_ready  in  1  consumer accepts output
- out_immediate  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag matching out_immediate
- out_illegal  out  1  ImmSrc was an unused encoding

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n is low, regardless of clk:
  - out_valid=0, out_immediate=0, out_tag=0, out_illegal=0
  - both skid entries are empty
  - in_ready=1 in the first cycle after release
- Reset mid-transfer discards all held entries.
- Encodings:
  - I=0: ins[31:20]
  - S=1: {ins[31:25],ins[11:7]}
  - B=2: {ins[31],ins[7],ins[30:25],ins[11:8],1'b0}
  - U=3: {ins[31:12],12'b0}
  - J=4: {ins[31],ins[19:12],ins[20],ins[30:21],1'b0}
  - Z=5: ins[19:15] zero-extended
- Extension: I/S/B/U/J sign-extend from ins[31] to XLEN. For XLEN=64, U-type is sign-extended from bit 31.
- Codes 6 and 7 are illegal: out_immediate=0 and out_illegal=1, with out_tag passed through normally.
- Accept: a transfer is accepted on in_valid && in_ready.
- Latency: 1 cycle from accept to out_valid when the output is empty or draining. Throughput is 1 per cycle under continuous out_ready=1.
- Storage: a main output register plus one skid register.
  - in_ready is a registered signal = skid entry empty; it has no combinational path from out_ready.
- State machine skid_state, transitions on clk:
  - EMPTY --accept--> ONE
  - ONE: accept && !drain -> FULL; drain && !accept -> EMPTY; accept && drain -> ONE
  - FULL: drain -> ONE (skid moves to the output register); no accept is possible
- drain = out_valid && out_ready.
- Simultaneous accept and drain in ONE: the output register loads the new data directly.
- Ordering is strictly FIFO; no transaction is dropped or duplicated.
- Outputs are stable while out_valid=1 and out_ready=0.
- Inputs are ignored when in_valid=0.

Optional Feature:
- IMM_GEN_ILLEGAL_CNT_EN defined:
  - Adds output port illegal_cnt (16 bits).
  - Increments on every accepted transaction whose ImmSrc is 6 or 7.
  - Saturates at 0xFFFF.
  - Cleared only by rst_n.
- Undefined: the port and counter are absent; out_illegal behaviour is unchanged.

Decomposition:
- Package immediate_generator_pkg holds:
  - typedef enum logic [2:0] imm_src_e {I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, Z_TYPE}
  - function imm_extract(instr, src) returning 32-bit sign-extended value plus an illegal flag
  - localparam IMM_W=32
- Sub-module imm_skid_buf, parametrised on payload width (XLEN+TAG_W+1), contains the handshake and state machine.
- Top level is extraction logic plus one imm_skid_buf instance.

Test Plan:
- XLEN=32, back-to-back with out_ready=1:
  - I 0xFFF00093 -> 0xFFFFFFFF
  - S 0xFE112E23 -> 0xFFFFFFFC
  - J 0xFF9FF06F -> 0xFFFFFFF8
  - One result per cycle, latency 1, tags in order.
- XLEN=64, U type:
  - 0x123450B7 -> 0x0000000012345000
  - 0x800000B7 -> 0xFFFFFFFF80000000
  - Z 0x0002D073 -> 0x5
- Backpressure: in_valid=1 streaming tags 1..6, out_ready=0 for 3 cycles.
  - in_ready falls after 2 accepts; tag 1 is held stable on the output.
  - After release, tags 1..6 emerge exactly once, in order.
- ImmSrc=7 with tag 0x5A -> out_immediate=0, out_illegal=1, out_tag=0x5A.
  - With IMM_GEN_ILLEGAL_CNT_EN, illegal_cnt goes 0->1; forced to 0xFFFF it stays at 0xFFFF.
- Reset in FULL state: assert rst_n=0 between clock edges.
  - out_valid drops immediately.
  - After release in_ready=1, and no stale data appears.
